// File: rtl/dds_key_ctrl.sv
// Four-key front end for the dual-channel AD9767 DDS generator.
// Each active-low push-button is synchronised and debounced on its own.
// Every accepted press steps one setting:
//   key 0 / key 1 : frequency index of channel 1 / 2 (eight-entry table)
//   key 2 / key 3 : phase word of channel 1 / 2 (PHASE_STEP per press)
module dds_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PHASE_STEP      = 512
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Key,
  output logic [31:0] Fword1,
  output logic [31:0] Fword2,
  output logic [11:0] Pword1,
  output logic [11:0] Pword2,
  output logic [3:0]  Key_Pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0] PHASE_INC = 12'(PHASE_STEP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } deb_state_t;

  // Frequency words for 50 MHz / 2^32 scaling, 1 kHz up to 10 MHz.
  function automatic logic [31:0] freq_lut(input logic [2:0] idx);
    logic [31:0] word;
    case (idx)
      3'd0:    word = 32'd85899;
      3'd1:    word = 32'd858993;
      3'd2:    word = 32'd8589935;
      3'd3:    word = 32'd42949673;
      3'd4:    word = 32'd85899346;
      3'd5:    word = 32'd171798692;
      3'd6:    word = 32'd429496730;
      default: word = 32'd858993459;
    endcase
    return word;
  endfunction

  logic [3:0] sync_a;
  logic [3:0] sync_b;

  // Two-flop synchroniser for the asynchronous buttons, idling at "released".
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_a <= 4'hF;
      sync_b <= 4'hF;
    end else begin
      sync_a <= Key;
      sync_b <= sync_a;
    end
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_deb
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse;
    logic             pulse_nxt;

    // Debounce state, filter counter and registered accept strobe.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        state <= IDLE;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        pulse <= pulse_nxt;
      end
    end

    // A level must persist for a full filter window before the state flips;
    // only the released-to-pressed acceptance produces a strobe.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pulse_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (!sync_b[gi]) begin
            state_nxt = FILT_DN;
            cnt_nxt   = '0;
          end
        end
        FILT_DN: begin
          if (sync_b[gi]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = DOWN;
            cnt_nxt   = '0;
            pulse_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DOWN: begin
          if (sync_b[gi]) begin
            state_nxt = FILT_UP;
            cnt_nxt   = '0;
          end
        end
        FILT_UP: begin
          if (!sync_b[gi]) begin
            state_nxt = DOWN;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign Key_Pulse[gi] = pulse;
  end

  logic [2:0] idx1;
  logic [2:0] idx2;

  // Frequency index steps per strobe and wraps 7 -> 0; the word is loaded
  // from the table together with the new index so it stays registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx1   <= 3'd0;
      idx2   <= 3'd0;
      Fword1 <= freq_lut(3'd0);
      Fword2 <= freq_lut(3'd0);
    end else begin
      if (Key_Pulse[0]) begin
        idx1   <= idx1 + 3'd1;
        Fword1 <= freq_lut(idx1 + 3'd1);
      end
      if (Key_Pulse[1]) begin
        idx2   <= idx2 + 3'd1;
        Fword2 <= freq_lut(idx2 + 3'd1);
      end
    end
  end

  // Phase words advance by PHASE_STEP per strobe, wrapping modulo 4096.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Pword1 <= 12'd0;
      Pword2 <= 12'd0;
    end else begin
      if (Key_Pulse[2]) Pword1 <= Pword1 + PHASE_INC;
      if (Key_Pulse[3]) Pword2 <= Pword2 + PHASE_INC;
    end
  end

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Self-checking bench for dds_key_ctrl with a 500-cycle debounce filter.
// The reference model only tracks how many presses each key has had and
// derives the expected words from that count.
module tb_dds_key_ctrl;

  localparam int DEB = 500;

  logic        Clk;
  logic        Reset;
  logic [3:0]  Key;
  logic [31:0] Fword1;
  logic [31:0] Fword2;
  logic [11:0] Pword1;
  logic [11:0] Pword2;
  logic [3:0]  Key_Pulse;

  dds_key_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .PHASE_STEP     (512)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Key      (Key),
    .Fword1   (Fword1),
    .Fword2   (Fword2),
    .Pword1   (Pword1),
    .Pword2   (Pword2),
    .Key_Pulse(Key_Pulse)
  );

  // 50 MHz clock.
  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int presses [4];
  int exp_pulses = 0;
  int pulse_total = 0;
  logic [3:0] prev_pulse = 4'h0;

  logic [31:0] freq_table [8] = '{32'd85899, 32'd858993, 32'd8589935,
                                  32'd42949673, 32'd85899346, 32'd171798692,
                                  32'd429496730, 32'd858993459};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Count every strobe and make sure none lasts longer than one cycle.
  always @(negedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (Key_Pulse[i] === 1'b1) begin
        pulse_total++;
        checkOutput("pulse_width", {31'd0, prev_pulse[i]}, 32'd0);
      end
    end
    prev_pulse = Key_Pulse;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic recordPress(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        presses[i]++;
        exp_pulses++;
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("fword1", Fword1, freq_table[presses[0] % 8]);
    checkOutput("fword2", Fword2, freq_table[presses[1] % 8]);
    checkOutput("pword1", {20'd0, Pword1}, 32'((presses[2] * 512) % 4096));
    checkOutput("pword2", {20'd0, Pword2}, 32'((presses[3] * 512) % 4096));
    checkOutput("pulse_idle", {28'd0, Key_Pulse}, 32'd0);
    checkOutput("pulse_count", 32'(pulse_total), 32'(exp_pulses));
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset = 1'b1;
    waitCycles(2);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) presses[i] = 0;
    checkModel();
  endtask

  // One press of every key in mask, with optional bounce at both edges.
  task automatic applyStimulus(input logic [3:0] mask, input int bounces,
                               input int blen);
    for (int b = 0; b < bounces; b++) begin
      Key = ~mask;
      waitCycles(blen);
      Key = 4'hF;
      waitCycles(blen);
    end
    Key = ~mask;
    waitCycles(1500);
    for (int b = 0; b < bounces; b++) begin
      Key = 4'hF;
      waitCycles(blen);
      Key = ~mask;
      waitCycles(blen);
    end
    Key = 4'hF;
    waitCycles(600);
    recordPress(mask);
    checkModel();
  endtask

  // A low pulse shorter than the filter window must be ignored.
  task automatic applyGlitch(input logic [3:0] mask, input int len);
    Key = ~mask;
    waitCycles(len);
    Key = 4'hF;
    waitCycles(600);
    checkModel();
  endtask

  // Called between edges with the keys already driven low: the strobe must
  // appear exactly 2 + DEB edges after the first sampling edge, the words
  // one edge later.
  task automatic waitPulse(input logic [3:0] mask);
    @(posedge Clk);
    repeat (DEB + 1) @(posedge Clk);
    #1 checkOutput("pulse_early", {28'd0, Key_Pulse}, 32'd0);
    @(posedge Clk);
    #1 checkOutput("pulse_edge", {28'd0, Key_Pulse}, {28'd0, mask});
    recordPress(mask);
    @(posedge Clk);
    #1 checkModel();
  endtask

  int counts [4] = '{4, 5, 4, 7};
  logic [3:0] mask;

  initial begin
    Reset = 1'b1;
    Key   = 4'hF;
    for (int i = 0; i < 4; i++) presses[i] = 0;
    waitCycles(3);
    Reset = 1'b0;

    // Idle after reset: reset words, no strobes.
    waitCycles(100);
    checkModel();

    // Mixed press counts on all four keys.
    for (int r = 0; r < 7; r++) begin
      mask = 4'h0;
      for (int i = 0; i < 4; i++) if (r < counts[i]) mask[i] = 1'b1;
      applyStimulus(mask, 0, 0);
    end
    checkOutput("total_pulses", 32'(pulse_total), 32'd20);

    // Reset while key 2 is filtering, then it must refilter from scratch.
    @(negedge Clk);
    Key = 4'b1011;
    waitCycles(100);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) presses[i] = 0;
    checkModel();
    waitPulse(4'b0100);
    @(negedge Clk);
    Key = 4'hF;
    waitCycles(600);
    checkModel();

    // Wrap-around of the frequency index and phase word.
    doReset();
    for (int r = 0; r < 9; r++) begin
      mask = (r < 8) ? 4'b0101 : 4'b0001;
      applyStimulus(mask, 0, 0);
    end

    // Short glitch and a heavily bouncing press on key 1.
    applyGlitch(4'b0010, 250);
    applyStimulus(4'b0010, 4, 50);

    // Keys 0 and 3 falling on the same edge.
    doReset();
    @(negedge Clk);
    Key = 4'b0110;
    waitPulse(4'b1001);
    @(negedge Clk);
    waitCycles(900);
    Key = 4'hF;
    waitCycles(600);
    checkModel();

    // Random masks, bounce and glitches.
    for (int r = 0; r < 5; r++) begin
      if ($urandom_range(0, 1) == 1)
        applyGlitch(4'($urandom_range(1, 15)), $urandom_range(20, 400));
      applyStimulus(4'($urandom_range(1, 15)), $urandom_range(0, 4),
                    $urandom_range(5, 150));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_key_ctrl.md
Name: dds_key_ctrl

Overview:
Four-key front end for the dual-channel AD9767 DDS generator. It debounces four active-low push-buttons and turns each accepted press into a step of a frequency or phase setting:
- Key[0]: channel 1 frequency
- Key[1]: channel 2 frequency
- Key[2]: channel 1 phase
- Key[3]: channel 2 phase

It sits directly upstream of the DDS core and drives that core's frequency-word and phase-word inputs.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, clocks a key level must stay stable before it is accepted (20 ms at 50 MHz); benches use 500.
PHASE_STEP, 512, phase-word increment per press (45 deg of 4096).

Ports:
Clk  input  1  system clock, 50 MHz
Reset  input  1  synchronous, active-high reset
Key  input  4  raw push-buttons; 1 = released, 0 = pressed; asynchronous
Fword1  output  32  channel 1 frequency word
Fword2  output  32  channel 2 frequency word
Pword1  output  12  channel 1 phase word
Pword2  output  12  channel 2 phase word
Key_Pulse  output  4  one-cycle accepted-press strobe per key (debug/LED)

Behaviour:
Synchronizer:
- Each Key bit passes through a 2-FF synchronizer; synchronizer regs reset to 1.

Debounce FSM (one per key, fully independent):
- States: IDLE (stable released), FILT_DN, DOWN (stable pressed), FILT_UP.
- IDLE: synced level 0 -> FILT_DN, counter cleared.
- FILT_DN: level returns to 1 -> IDLE with counter cleared. Level still 0 with counter == DEBOUNCE_CYCLES-1 -> DOWN, Key_Pulse[i]=1 for exactly that one cycle. Otherwise counter+1.
- DOWN: level 1 -> FILT_UP, counter cleared.
- FILT_UP: level returns to 0 -> DOWN. Level still 1 with counter == DEBOUNCE_CYCLES-1 -> IDLE, no pulse. Otherwise counter+1.
- Counter width is clog2(DEBOUNCE_CYCLES).
- Only one pulse per press; holding a key never repeats.

Frequency stepping:
- 3-bit index per channel; each Key_Pulse[0]/[1] does index = index+1, and 7 wraps to 0.
- Fword = LUT(index), 50 MHz / 2^32 scaling:
  - 0: 85899 (1 kHz)
  - 1: 858993 (10 kHz)
  - 2: 8589935 (100 kHz)
  - 3: 42949673 (500 kHz)
  - 4: 85899346 (1 MHz)
  - 5: 171798692 (2 MHz)
  - 6: 429496730 (5 MHz)
  - 7: 858993459 (10 MHz)

Phase stepping:
- Each Key_Pulse[2]/[3] does Pword = Pword + PHASE_STEP, modulo 4096 (3584 -> 0 for the default).

Output timing:
- All outputs are registered.
- Fword/Pword change on the clock edge after the Key_Pulse cycle.
- Total latency from the first edge sampling Key low: 2 (sync) + DEBOUNCE_CYCLES + 1 edges.
- Key_Pulse is high exactly 2 + DEBOUNCE_CYCLES edges after that first sampling edge.

Concurrency:
- Simultaneous pulses on different keys are all applied in the same cycle; no priority is needed since each key owns its own register.

Reset values (Reset=1 on any edge, including mid-filter or mid-press):
- All FSMs go to IDLE; counters 0; synchronizers 1.
- Indexes 0, so Fword1 = Fword2 = 85899.
- Pword1 = Pword2 = 0; Key_Pulse = 0.
- A key held low through reset release must complete a full FILT_DN before it is accepted.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=500, a 20 ns clock, and a press of 30 us low followed by 10 us high.)
1. Reset released, no keys -> Fword1 = Fword2 = 85899, Pword1 = Pword2 = 0, Key_Pulse stays 0.
2. Key[0] x4, Key[1] x5, Key[2] x4, Key[3] x7 -> Fword1 = 85899346, Fword2 = 171798692, Pword1 = 2048, Pword2 = 3584. Exactly 20 Key_Pulse strobes, each 1 cycle wide.
3. Wrap-around:
   - Key[0] x9 -> Fword1 = 858993.
   - Key[2] x8 -> Pword1 = 0.
4. Glitch/bounce:
   - Key[1] low 5 us then high -> no change.
   - Key[1] toggling every 1 us for 8 us, then held low 30 us, then bouncing on release -> Fword2 advances by exactly one table step.
5. Simultaneous: Key[0] and Key[3] falling on the same edge -> Key_Pulse = 4'b1001 in one cycle; Fword1 = 858993 and Pword2 = 512 on the next edge.
6. Reset mid-operation:
   - After the scenario 2 settings, assert Reset for 1 cycle while Key[2] is in FILT_DN -> all outputs return to reset values.
   - Keep Key[2] low -> Pword1 = 512 only after a full 500-cycle filter.
